// File: rtl/pipeline_types_pkg.sv
// pipeline_types_pkg: shared mul/div op encoding, iteration count and operand magnitude helper
package pipeline_types_pkg;
  typedef enum logic [1:0] {OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11} mdu_op_t;
  localparam int MDU_ITER = 32;
  function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
    return (s && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration (i_div=0 shift-add multiply, i_div=1 restoring divide) on {i_hi,i_lo} with operand i_m
module mdu_step (
  input  logic        i_div,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_m,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);
  logic [32:0] w_sum, w_rem, w_diff;
  always_comb begin
    w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : 33'd0);
    w_rem  = {i_hi, i_lo[31]};
    w_diff = w_rem - {1'b0, i_m};
    o_hi   = i_div ? (w_diff[32] ? w_rem[31:0] : w_diff[31:0]) : w_sum[32:1];
    o_lo   = i_div ? {i_lo[30:0], ~w_diff[32]} : {w_sum[0], i_lo[31:1]};
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: 32-cycle iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; ports clk rst start op a b flush hilo_we hiwd lowd -> busy done dz hi lo
module mdu_ctrl
  import pipeline_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hilo_we,
  input  logic [31:0] hiwd,
  input  logic [31:0] lowd,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_acc_hi, r_acc_lo, r_m, r_hi, r_lo;
  logic        r_div, r_neg_q, r_neg_r, r_dz;
  logic        w_signed, w_isdiv;
  logic [31:0] w_step_hi, w_step_lo, w_q, w_r;
  logic [63:0] w_prod, w_prod_s;
  mdu_op_t     w_op;
  assign w_op     = mdu_op_t'(op);
  assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
  assign w_isdiv  = (w_op == OP_DIVU) || (w_op == OP_DIV);
  mdu_step u_step (
    .i_div(r_div),
    .i_hi (r_acc_hi),
    .i_lo (r_acc_lo),
    .i_m  (r_m),
    .o_hi (w_step_hi),
    .o_lo (w_step_lo)
  );
  assign w_prod   = {r_acc_hi, r_acc_lo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_q      = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? -r_acc_lo : r_acc_lo);
  assign w_r      = r_neg_r ? -r_acc_hi : r_acc_hi;
  assign busy     = r_state != S_IDLE;
  assign done     = (r_state == S_FIN) && !flush && !rst;
  assign dz       = done && r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_m      <= '0;
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (hilo_we) begin
            r_hi <= hiwd;
            r_lo <= lowd;
          end
          if (start && !flush) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_div    <= w_isdiv;
            r_neg_q  <= w_signed && (a[31] ^ b[31]);
            r_neg_r  <= w_signed && w_isdiv && a[31];
            r_dz     <= w_isdiv && (b == '0);
            r_acc_hi <= '0;
            // the shifted operand sits in acc_lo: multiplier for mul, dividend for div
            r_acc_lo <= w_isdiv ? mag(a, w_signed) : mag(b, w_signed);
            r_m      <= w_isdiv ? mag(b, w_signed) : mag(a, w_signed);
          end
        end
        S_RUN: begin
          if (flush) r_state <= S_IDLE;
          else begin
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
            r_cnt    <= r_cnt + 6'd1;
            if (r_cnt == 6'(MDU_ITER - 1)) r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          if (!flush) begin
            r_hi <= r_div ? w_r : w_prod_s[63:32];
            r_lo <= r_div ? w_q : w_prod_s[31:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
